seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 11 +
 rtl/seg_scan_ctrl_if.sv | 10 +
 rtl/seg_scan_ctrl.sv | 81 ++++++++
 tb/tb_seg_scan_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_ctrl_pkg;
  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  localparam int         DIGITS    = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam int         CNT_W     = 8;
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame write handshake: requester (master) pushes a 4-digit frame plus blank mask.
interface seg_scan_ctrl_if;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic [3:0]  wr_blank;
  logic        wr_ready;

  modport master (output wr_valid, wr_data, wr_blank, input  wr_ready);
  modport slave  (input  wr_valid, wr_data, wr_blank, output wr_ready);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scanner with blanking gaps between digits and
// a pending/shadow frame buffer that only swaps on the 3->0 wrap.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int BLANK_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  seg_scan_ctrl_if.slave   wr,
  output logic [3:0]       anode,
  output logic [3:0]       nibble,
  output logic [1:0]       digit_idx,
  output logic             frame_done
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [1:0]       LAST_DIG = 2'(DIGITS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      shadow_data, pend_data;
  logic [3:0]       shadow_blank, pend_blank;
  logic             pend_full;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= BLANK;
      cnt          <= CNT_LOAD;
      digit_idx    <= LAST_DIG;
      shadow_data  <= '0;
      shadow_blank <= ANODE_OFF;
      pend_data    <= '0;
      pend_blank   <= '0;
      pend_full    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // Accept and copy are exclusive: accept needs empty, copy needs full.
      if (wr.wr_valid && !pend_full) begin
        pend_data  <= wr.wr_data;
        pend_blank <= wr.wr_blank;
        pend_full  <= 1'b1;
      end
      case (state)
        SHOW: begin
          if (tick) begin
            state <= BLANK;
            cnt   <= CNT_LOAD;
          end
        end
        BLANK: begin
          if (cnt == '0) begin
            state     <= SHOW;
            digit_idx <= digit_idx + 2'd1;
            if (digit_idx == LAST_DIG) begin
              frame_done <= 1'b1;
              if (pend_full) begin
                shadow_data  <= pend_data;
                shadow_blank <= pend_blank;
                pend_full    <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  assign wr.wr_ready = !pend_full;
  assign nibble      = shadow_data[4*digit_idx +: 4];

  always_comb begin
    anode = ANODE_OFF;
    if (state == SHOW && !shadow_blank[digit_idx])
      anode[digit_idx] = 1'b0;
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with BLANK_CYCLES=2 and hand-computed expectations.
module tb_seg_scan_ctrl;
  logic       clock = 1'b0;
  logic       reset, tick;
  logic [3:0] anode, nibble;
  logic [1:0] digit_idx;
  logic       frame_done;
  int         vecs = 0;
  int         errs = 0;

  seg_scan_ctrl_if wif();

  seg_scan_ctrl #(.BLANK_CYCLES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .wr         (wif),
    .anode      (anode),
    .nibble     (nibble),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One tick pulse, then ride out the 2-cycle blank gap to the next digit.
  task automatic advance();
    tick = 1'b1;
    step();
    chk("gap_anode0", 16'(anode), 16'hf);
    tick = 1'b0;
    step();
    chk("gap_anode1", 16'(anode), 16'hf);
    step();
  endtask

  task automatic wr_now(input logic [15:0] d, input logic [3:0] b);
    chk("wr_ready_pre", 16'(wif.wr_ready), 16'h1);
    wif.wr_valid = 1'b1;
    wif.wr_data  = d;
    wif.wr_blank = b;
    step();
    wif.wr_valid = 1'b0;
    chk("wr_ready_post", 16'(wif.wr_ready), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int changes;
    logic [1:0] prev;
    reset = 1'b1; tick = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_data = '0; wif.wr_blank = '0;
    step(); step();
    chk("rst_anode", 16'(anode), 16'hf);
    chk("rst_ready", 16'(wif.wr_ready), 16'h1);
    chk("rst_fd", 16'(frame_done), 16'h0);
    chk("rst_nib", 16'(nibble), 16'h0);
    chk("rst_idx", 16'(digit_idx), 16'h3);

    reset = 1'b0;
    step();
    chk("boot_anode", 16'(anode), 16'hf);
    chk("boot_idx", 16'(digit_idx), 16'h3);
    step();
    chk("boot_wrap_idx", 16'(digit_idx), 16'h0);
    chk("boot_wrap_fd", 16'(frame_done), 16'h1);
    chk("boot_wrap_anode", 16'(anode), 16'hf);
    step();
    chk("boot_fd_clear", 16'(frame_done), 16'h0);

    // 1234 waits for the next wrap before appearing
    wr_now(16'h1234, 4'h0);
    advance(); advance(); advance();
    chk("pre_wrap_idx", 16'(digit_idx), 16'h3);
    chk("pre_wrap_anode", 16'(anode), 16'hf);
    chk("pre_wrap_ready", 16'(wif.wr_ready), 16'h0);
    advance();
    chk("f1_d0_fd", 16'(frame_done), 16'h1);
    chk("f1_d0_anode", 16'(anode), 16'he);
    chk("f1_d0_nib", 16'(nibble), 16'h4);
    chk("f1_d0_ready", 16'(wif.wr_ready), 16'h1);

    // ABCD accepted mid-frame; second request held until after the copy
    wr_now(16'hABCD, 4'h0);
    chk("f1_d0_fd_drop", 16'(frame_done), 16'h0);
    advance();
    chk("f1_d1_anode", 16'(anode), 16'hd);
    chk("f1_d1_nib", 16'(nibble), 16'h3);
    wif.wr_valid = 1'b1; wif.wr_data = 16'h1234; wif.wr_blank = 4'b0101;
    step();
    chk("held_ready", 16'(wif.wr_ready), 16'h0);
    advance();
    chk("f1_d2_anode", 16'(anode), 16'hb);
    chk("f1_d2_nib", 16'(nibble), 16'h2);
    chk("f1_d2_ready", 16'(wif.wr_ready), 16'h0);
    advance();
    chk("f1_d3_anode", 16'(anode), 16'h7);
    chk("f1_d3_nib", 16'(nibble), 16'h1);
    chk("f1_d3_ready", 16'(wif.wr_ready), 16'h0);
    advance();
    chk("f2_d0_idx", 16'(digit_idx), 16'h0);
    chk("f2_d0_fd", 16'(frame_done), 16'h1);
    chk("f2_d0_nib", 16'(nibble), 16'hd);
    chk("f2_d0_anode", 16'(anode), 16'he);
    chk("f2_d0_ready", 16'(wif.wr_ready), 16'h1);
    step();
    wif.wr_valid = 1'b0;
    chk("f2_held_accept", 16'(wif.wr_ready), 16'h0);
    chk("f2_d0_nib_hold", 16'(nibble), 16'hd);
    advance();
    chk("f2_d1_nib", 16'(nibble), 16'hc);
    advance();
    chk("f2_d2_nib", 16'(nibble), 16'hb);
    advance();
    chk("f2_d3_nib", 16'(nibble), 16'ha);
    chk("f2_d3_anode", 16'(anode), 16'h7);

    // 1234 with blank mask 0101: digits 0 and 2 stay dark
    advance();
    chk("f3_d0_fd", 16'(frame_done), 16'h1);
    chk("f3_d0_anode", 16'(anode), 16'hf);
    chk("f3_d0_nib", 16'(nibble), 16'h4);
    advance();
    chk("f3_d1_anode", 16'(anode), 16'hd);
    chk("f3_d1_nib", 16'(nibble), 16'h3);
    advance();
    chk("f3_d2_anode", 16'(anode), 16'hf);
    chk("f3_d2_nib", 16'(nibble), 16'h2);
    advance();
    chk("f3_d3_anode", 16'(anode), 16'h7);
    chk("f3_d3_nib", 16'(nibble), 16'h1);

    // Continuous tick: one advance per 3 cycles at most
    tick = 1'b1;
    changes = 0;
    prev = digit_idx;
    for (int i = 0; i < 9; i++) begin
      step();
      if (digit_idx != prev) changes++;
      prev = digit_idx;
    end
    chk("cont_tick_changes", 16'(changes), 16'd3);
    chk("cont_tick_idx", 16'(digit_idx), 16'h2);
    tick = 1'b0;

    // Reset mid-blank with a frame pending: pending is dropped
    wr_now(16'hFFFF, 4'h0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("preblank_anode", 16'(anode), 16'hf);
    reset = 1'b1;
    step();
    chk("rst2_anode", 16'(anode), 16'hf);
    chk("rst2_ready", 16'(wif.wr_ready), 16'h1);
    chk("rst2_idx", 16'(digit_idx), 16'h3);
    chk("rst2_fd", 16'(frame_done), 16'h0);
    chk("rst2_nib", 16'(nibble), 16'h0);
    reset = 1'b0;
    tick = 1'b1;
    step();
    chk("rst2_boot_idx", 16'(digit_idx), 16'h3);
    step();
    chk("rst2_wrap_idx", 16'(digit_idx), 16'h0);
    chk("rst2_wrap_fd", 16'(frame_done), 16'h1);
    chk("rst2_wrap_anode", 16'(anode), 16'hf);
    chk("rst2_wrap_nib", 16'(nibble), 16'h0);
    chk("rst2_wrap_ready", 16'(wif.wr_ready), 16'h1);
    tick = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
